// File: rtl/sm_input_pkg.sv
// Shared constants for the key/switch input peripheral.
//   REG_*      : word offsets decoded from a[3:2]
//   EVT_CNT_W  : width of the press-event counter
package sm_input_pkg;

  localparam logic [1:0] REG_SWITCH      = 2'd0;
  localparam logic [1:0] REG_KEY_LEVEL   = 2'd1;
  localparam logic [1:0] REG_KEY_EDGE    = 2'd2;
  localparam logic [1:0] REG_EVENT_COUNT = 2'd3;

  localparam int EVT_CNT_W = 16;

endpackage

// File: rtl/sm_debounce.sv
// Single-key debouncer. Accepts a level change only after the synchronized
// input has differed from the current stable level for debounceCycles
// consecutive cycles; any return to the stable level restarts the count.
// Ports:
//   clk, rst_p : clock, async active-high reset
//   in_sync    : already-synchronized key level
//   stable     : debounced level
//   press      : registered one-cycle pulse when stable goes 0->1
module sm_debounce #(
  parameter int debounceCycles = 50000
) (
  input  logic clk,
  input  logic rst_p,
  input  logic in_sync,
  output logic stable,
  output logic press
);

  localparam int CW = $clog2(debounceCycles + 1);
  localparam logic [CW-1:0] LAST = CW'(debounceCycles - 1);

  logic          stable_q;
  logic          press_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst_p) begin
    if (rst_p) begin
      stable_q <= 1'b0;
      press_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      press_q <= 1'b0;
      if (in_sync == stable_q) begin
        cnt_q <= '0;
      end else if (cnt_q == LAST) begin
        stable_q <= in_sync;
        cnt_q    <= '0;
        press_q  <= in_sync;  // releases update the level but are not events
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign stable = stable_q;
  assign press  = press_q;

endmodule

// File: rtl/sm_input_from_keys.sv
// Memory-mapped switch/button input register block.
// Ports:
//   clk, rst_p    : clock, async active-high reset
//   a             : byte address, only a[3:2] used
//   we, wd        : write strobe and data (pre-qualified by external decoder)
//   rd            : combinational read data
//   keys_raw      : async push-buttons, 1 = pressed
//   switches_raw  : async slide switches
// Registers: 0 SWITCH (ro), 1 KEY_LEVEL (ro), 2 KEY_EDGE (sticky, W1C),
//            3 EVENT_COUNT (any write reloads with this cycle's presses).
module sm_input_from_keys
  import sm_input_pkg::*;
#(
  parameter int keyCount       = 4,
  parameter int switchCount    = 10,
  parameter int debounceCycles = 50000
) (
  input  logic                   clk,
  input  logic                   rst_p,
  input  logic [31:0]            a,
  input  logic                   we,
  input  logic [31:0]            wd,
  output logic [31:0]            rd,
  input  logic [keyCount-1:0]    keys_raw,
  input  logic [switchCount-1:0] switches_raw
);

  logic [switchCount-1:0] sw_s1_q, sw_s2_q;
  logic [keyCount-1:0]    key_s1_q, key_s2_q;
  logic [keyCount-1:0]    stable, press;
  logic [keyCount-1:0]    edge_q, edge_d, edge_clr;
  logic [EVT_CNT_W-1:0]   count_q, count_d, press_cnt;
  logic                   wr_edge, wr_count;

  // 2-FF synchronizers
  always_ff @(posedge clk or posedge rst_p) begin
    if (rst_p) begin
      sw_s1_q  <= '0;
      sw_s2_q  <= '0;
      key_s1_q <= '0;
      key_s2_q <= '0;
    end else begin
      sw_s1_q  <= switches_raw;
      sw_s2_q  <= sw_s1_q;
      key_s1_q <= keys_raw;
      key_s2_q <= key_s1_q;
    end
  end

  for (genvar i = 0; i < keyCount; i++) begin : g_key
    sm_debounce #(.debounceCycles(debounceCycles)) u_db (
      .clk    (clk),
      .rst_p  (rst_p),
      .in_sync(key_s2_q[i]),
      .stable (stable[i]),
      .press  (press[i])
    );
  end

  assign wr_edge  = we && (a[3:2] == REG_KEY_EDGE);
  assign wr_count = we && (a[3:2] == REG_EVENT_COUNT);
  assign edge_clr = wr_edge ? wd[keyCount-1:0] : '0;

  always_comb begin
    press_cnt = '0;
    for (int i = 0; i < keyCount; i++)
      press_cnt = press_cnt + {{(EVT_CNT_W-1){1'b0}}, press[i]};
  end

  // Set after clear so a press in the clearing cycle survives; a counter
  // write reloads with this cycle's presses so none are dropped.
  assign edge_d  = (edge_q & ~edge_clr) | press;
  assign count_d = wr_count ? press_cnt : count_q + press_cnt;

  always_ff @(posedge clk or posedge rst_p) begin
    if (rst_p) begin
      edge_q  <= '0;
      count_q <= '0;
    end else begin
      edge_q  <= edge_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    rd = '0;
    case (a[3:2])
      REG_SWITCH:      rd = 32'(sw_s2_q);
      REG_KEY_LEVEL:   rd = 32'(stable);
      REG_KEY_EDGE:    rd = 32'(edge_q);
      REG_EVENT_COUNT: rd = {{(32-EVT_CNT_W){1'b0}}, count_q};
      default:         rd = '0;
    endcase
  end

  logic unused_ok;
  assign unused_ok = ^{a[31:4], a[1:0], wd[31:keyCount]};

endmodule

// File: tb/tb_sm_input_from_keys.sv
module tb_sm_input_from_keys;

  localparam int KC = 4;
  localparam int SC = 10;
  localparam int DB = 4;

  localparam logic [1:0] R_SW  = 2'd0;
  localparam logic [1:0] R_LVL = 2'd1;
  localparam logic [1:0] R_EDG = 2'd2;
  localparam logic [1:0] R_CNT = 2'd3;

  logic          clk = 1'b0;
  logic          rst_p;
  logic [31:0]   a;
  logic          we;
  logic [31:0]   wd;
  logic [31:0]   rd;
  logic [KC-1:0] keys_raw;
  logic [SC-1:0] switches_raw;

  sm_input_from_keys #(
    .keyCount(KC), .switchCount(SC), .debounceCycles(DB)
  ) dut (
    .clk(clk), .rst_p(rst_p), .a(a), .we(we), .wd(wd), .rd(rd),
    .keys_raw(keys_raw), .switches_raw(switches_raw)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic [31:0] exp;
  } sb_t;

  sb_t  sb[$];
  event rd_ev;
  int   checks = 0;
  int   errors = 0;

  // Monitor: compares rd against the oldest expected entry whenever a read
  // is presented.
  initial begin
    sb_t e;
    forever begin
      @(rd_ev);
      #1;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty: read presented with no expectation, rd=%h", rd);
      end else begin
        e = sb.pop_front();
        if (rd !== e.exp) begin
          errors++;
          $display("FAIL %s: got %h expected %h", e.nm, rd, e.exp);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Upper/lower address bits are deliberately non-zero; only a[3:2] matters.
  task automatic rd_chk(input logic [1:0] r, input logic [31:0] exp, input string nm);
    sb_t e;
    a = {28'h5A5A5A5, r, 2'b11};
    e.nm = nm; e.exp = exp;
    sb.push_back(e);
    -> rd_ev;
    #2;
  endtask

  task automatic wr(input logic [1:0] r, input logic [31:0] d);
    a  = {28'hA5A5A5A, r, 2'b00};
    wd = d;
    we = 1'b1;
    @(posedge clk);
    #1;
    we = 1'b0;
    wd = '0;
  endtask

  task automatic rd_all0(input string nm);
    rd_chk(R_SW,  32'h0, nm);
    rd_chk(R_LVL, 32'h0, nm);
    rd_chk(R_EDG, 32'h0, nm);
    rd_chk(R_CNT, 32'h0, nm);
  endtask

  initial begin
    rst_p = 1'b1; a = '0; we = 1'b0; wd = '0;
    keys_raw = 4'hF; switches_raw = '0;

    // Reset with all keys held
    tick(2);
    rd_all0("reset_state");
    rst_p = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      tick(1);
      rd_all0("post_reset_quiet");
    end
    tick(1);
    rd_chk(R_LVL, 32'hF, "held_level");
    rd_chk(R_EDG, 32'h0, "held_edge_not_yet");
    tick(1);
    rd_chk(R_EDG, 32'hF, "held_edge");
    rd_chk(R_CNT, 32'd4, "held_count");
    keys_raw = 4'h0;
    tick(10);
    rd_chk(R_LVL, 32'h0, "release_level");
    rd_chk(R_CNT, 32'd4, "release_no_event");
    wr(R_EDG, 32'hF);
    rd_chk(R_EDG, 32'h0, "edge_clear_all");
    wr(R_CNT, 32'hDEAD);
    rd_chk(R_CNT, 32'h0, "count_reload_zero");

    // Switch latency and read-only behaviour
    switches_raw = 10'h2A5;
    tick(1);
    rd_chk(R_SW, 32'h0, "switch_1edge");
    tick(1);
    rd_chk(R_SW, 32'h2A5, "switch_2edge");
    wr(R_SW, 32'hFFFF_FFFF);
    rd_chk(R_SW, 32'h2A5, "switch_write_ignored");
    wr(R_LVL, 32'hFFFF_FFFF);
    rd_chk(R_LVL, 32'h0, "level_write_ignored");

    // Short glitch on key0 is rejected
    keys_raw = 4'h1;
    tick(3);
    keys_raw = 4'h0;
    tick(10);
    rd_chk(R_LVL, 32'h0, "glitch_level");
    rd_chk(R_EDG, 32'h0, "glitch_edge");
    rd_chk(R_CNT, 32'h0, "glitch_count");

    // Full press on key0, exact timing
    keys_raw = 4'h1;
    tick(5);
    rd_chk(R_LVL, 32'h0, "press_level_early");
    tick(1);
    rd_chk(R_LVL, 32'h1, "press_level");
    rd_chk(R_CNT, 32'h0, "press_count_early");
    tick(1);
    rd_chk(R_EDG, 32'h1, "press_edge");
    rd_chk(R_CNT, 32'h1, "press_count");
    keys_raw = 4'h0;
    tick(8);
    rd_chk(R_LVL, 32'h0, "press_release_level");
    rd_chk(R_CNT, 32'h1, "press_release_count");

    // Key1 press, then W1C of bit0 only
    keys_raw = 4'h2;
    tick(8);
    rd_chk(R_EDG, 32'h3, "edge_two_keys");
    rd_chk(R_CNT, 32'h2, "count_two");
    keys_raw = 4'h0;
    tick(8);
    wr(R_EDG, 32'h1);
    rd_chk(R_EDG, 32'h2, "edge_w1c_bit0");

    // Clear of bit1 in the same cycle as a key1 press pulse: set wins
    keys_raw = 4'h2;
    tick(6);
    wr(R_EDG, 32'h2);
    rd_chk(R_EDG, 32'h2, "edge_set_wins");
    rd_chk(R_CNT, 32'h3, "count_three");
    keys_raw = 4'h0;
    tick(8);
    wr(R_EDG, 32'hF);
    rd_chk(R_EDG, 32'h0, "edge_cleared");

    // Counter wrap
    force dut.count_q = 16'hFFFF;
    #1;
    release dut.count_q;
    rd_chk(R_CNT, 32'h0000_FFFF, "count_preset");
    keys_raw = 4'h1;
    tick(7);
    rd_chk(R_CNT, 32'h0, "count_wrap");
    rd_chk(R_EDG, 32'h1, "wrap_edge");
    keys_raw = 4'h0;
    tick(8);

    // Counter write coinciding with two press pulses
    keys_raw = 4'h3;
    tick(6);
    wr(R_CNT, 32'h1234);
    rd_chk(R_CNT, 32'h2, "count_write_keeps_presses");
    rd_chk(R_EDG, 32'h3, "dual_edge");
    keys_raw = 4'h0;
    tick(8);
    rd_chk(R_CNT, 32'h2, "count_after_dual");

    // Reset in the middle of a debounce (cnt=2)
    keys_raw = 4'h1;
    tick(4);
    rst_p = 1'b1;
    #1;
    rd_all0("midreset_state");
    tick(1);
    rst_p = 1'b0;
    tick(5);
    rd_chk(R_LVL, 32'h0, "midreset_no_early_accept");
    rd_chk(R_SW, 32'h2A5, "midreset_switch_resync");
    tick(1);
    rd_chk(R_LVL, 32'h1, "midreset_level");
    tick(1);
    rd_chk(R_EDG, 32'h1, "midreset_edge");
    rd_chk(R_CNT, 32'h1, "midreset_count");

    #2;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
